tlb_walk_fill: RTL and testbench

Hardware page-table walker that fills the TLB. On a TLB miss it walks the Sv39 page table in memory, one PTE read at a time, and on reaching a valid leaf it issues a single-cycle `TLBWrite` with the PTE and page size. That write is the strobe the TLB's replacement logic consumes. Invalid or malformed table entries end the walk with a fault pulse instead of a write. The block sits between the TLB/CAM and the data-side memory port.

---
 rtl/tlb_walk_fill.sv | 134 +++++++++++++
 tb/tb_tlb_walk_fill.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/tlb_walk_fill.sv
// Sv39 hardware page-table walker: reads one PTE per request on a TLB miss and
// ends each walk with either a single-cycle TLB fill strobe or a fault pulse.
module tlb_walk_fill #(
  parameter int PA_BITS  = 56,
  parameter int PPN_BITS = 44
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                TLBMiss,
  input  logic [26:0]         VPN,
  input  logic [PPN_BITS-1:0] SATP_PPN,
  input  logic                TLBFlush,
  output logic                MemReq,
  output logic [PA_BITS-1:0]  MemAdr,
  input  logic                MemValid,
  input  logic [63:0]         MemRData,
  output logic                TLBWrite,
  output logic [63:0]         PTE,
  output logic [1:0]          PageType,
  output logic                WalkFault,
  output logic                Busy
);

  typedef enum logic [2:0] {IDLE, REQ, DONE, FAULT, DRAIN} state_t;

  state_t              state;
  logic [1:0]          lvl;
  logic [PPN_BITS-1:0] base;
  logic [26:0]         vpn_q;
  logic                write_q;
  logic                fault_q;
  logic [8:0]          vpn_idx;

  logic                pte_v, pte_r, pte_w, pte_x;
  logic [PPN_BITS-1:0] pte_ppn;
  logic                is_leaf, bad_flags, misaligned;

  always_comb begin
    case (lvl)
      2'd2:    vpn_idx = vpn_q[26:18];
      2'd1:    vpn_idx = vpn_q[17:9];
      default: vpn_idx = vpn_q[8:0];
    endcase
  end

  assign MemAdr = PA_BITS'({base, 12'b0}) + PA_BITS'({vpn_idx, 3'b000});

  assign pte_v      = MemRData[0];
  assign pte_r      = MemRData[1];
  assign pte_w      = MemRData[2];
  assign pte_x      = MemRData[3];
  assign pte_ppn    = MemRData[10 +: PPN_BITS];
  assign bad_flags  = !pte_v || (!pte_r && pte_w);
  assign is_leaf    = pte_r || pte_x;
  assign misaligned = ((lvl == 2'd2) && (pte_ppn[17:0] != '0)) ||
                      ((lvl == 2'd1) && (pte_ppn[8:0] != '0));

  // A flush landing on the pulse cycle must still cancel the pulse, so the
  // registered pulse flags are masked by the live flush here.
  assign TLBWrite  = write_q && !TLBFlush;
  assign WalkFault = fault_q && !TLBFlush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      lvl      <= 2'd0;
      base     <= '0;
      vpn_q    <= '0;
      MemReq   <= 1'b0;
      PTE      <= '0;
      PageType <= 2'd0;
      write_q  <= 1'b0;
      fault_q  <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      write_q <= 1'b0;
      fault_q <= 1'b0;
      case (state)
        IDLE: begin
          if (TLBMiss && !TLBFlush) begin
            vpn_q  <= VPN;
            base   <= SATP_PPN;
            lvl    <= 2'd2;
            state  <= REQ;
            MemReq <= 1'b1;
            Busy   <= 1'b1;
          end
        end
        REQ: begin
          if (TLBFlush) begin
            MemReq <= 1'b0;
            if (MemValid) begin
              state <= IDLE;
              Busy  <= 1'b0;
            end else begin
              state <= DRAIN;
            end
          end else if (MemValid) begin
            if (bad_flags || (is_leaf && misaligned) || (!is_leaf && lvl == 2'd0)) begin
              state   <= FAULT;
              fault_q <= 1'b1;
              MemReq  <= 1'b0;
            end else if (is_leaf) begin
              PTE      <= MemRData;
              PageType <= lvl;
              state    <= DONE;
              write_q  <= 1'b1;
              MemReq   <= 1'b0;
            end else begin
              base <= pte_ppn;
              lvl  <= lvl - 2'd1;
            end
          end
        end
        DONE, FAULT: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        DRAIN: begin
          if (MemValid) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          MemReq <= 1'b0;
          Busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_walk_fill.sv
// Directed bench for tlb_walk_fill: walks of each page size, fault cases,
// flush handling and reset during a walk. Inputs change and outputs are sampled on negedges.
module tb_tlb_walk_fill;
  logic        clk = 1'b0;
  logic        reset, TLBMiss, TLBFlush, MemValid;
  logic [26:0] VPN;
  logic [43:0] SATP_PPN;
  logic [63:0] MemRData;
  logic        MemReq, TLBWrite, WalkFault, Busy;
  logic [55:0] MemAdr;
  logic [63:0] PTE;
  logic [1:0]  PageType;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  tlb_walk_fill #(.PA_BITS(56), .PPN_BITS(44)) dut (
    .clk(clk), .reset(reset), .TLBMiss(TLBMiss), .VPN(VPN), .SATP_PPN(SATP_PPN),
    .TLBFlush(TLBFlush), .MemReq(MemReq), .MemAdr(MemAdr), .MemValid(MemValid),
    .MemRData(MemRData), .TLBWrite(TLBWrite), .PTE(PTE), .PageType(PageType),
    .WalkFault(WalkFault), .Busy(Busy)
  );

  function automatic logic [63:0] mk_pte(input logic [43:0] ppn, input logic [3:0] xwrv);
    return {10'b0, ppn, 6'b0, xwrv};
  endfunction

  // Leaves the bench at the negedge of cycle t+1 (TLBMiss was high in cycle t).
  task automatic start_walk(input logic [43:0] satp, input logic [26:0] vpn);
    SATP_PPN = satp;
    VPN      = vpn;
    TLBMiss  = 1'b1;
    @(negedge clk);
    TLBMiss  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; TLBMiss = 0; TLBFlush = 0; MemValid = 0; VPN = '0; SATP_PPN = '0; MemRData = '0;
    @(negedge clk); @(negedge clk);
    total++; if (MemReq !== 1'b0) begin bad++; $display("FAIL reset_memreq got=%0h exp=0", MemReq); end
    total++; if (MemAdr !== 56'h0) begin bad++; $display("FAIL reset_memadr got=%0h exp=0", MemAdr); end
    total++; if ({TLBWrite, WalkFault, Busy} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {TLBWrite, WalkFault, Busy}); end
    total++; if ({PTE, PageType} !== 66'h0) begin bad++; $display("FAIL reset_pte got=%0h exp=0", {PTE, PageType}); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_walk_4k();
    logic [63:0] leaf;
    leaf = mk_pte(44'h8_1234, 4'b1111);
    start_walk(44'h80000, {9'd1, 9'd2, 9'd3});
    total++; if (MemReq !== 1'b1) begin bad++; $display("FAIL w4k_req1 got=%0h exp=1", MemReq); end
    total++; if (MemAdr !== 56'h8000_0008) begin bad++; $display("FAIL w4k_adr_l2 got=%0h exp=80000008", MemAdr); end
    MemValid = 1'b1; MemRData = mk_pte(44'h80001, 4'b0001);
    @(negedge clk);
    total++; if (MemReq !== 1'b1) begin bad++; $display("FAIL w4k_req2 got=%0h exp=1", MemReq); end
    total++; if (MemAdr !== 56'h8000_1010) begin bad++; $display("FAIL w4k_adr_l1 got=%0h exp=80001010", MemAdr); end
    MemRData = mk_pte(44'h80002, 4'b0001);
    @(negedge clk);
    total++; if (MemAdr !== 56'h8000_2018) begin bad++; $display("FAIL w4k_adr_l0 got=%0h exp=80002018", MemAdr); end
    MemRData = leaf;
    @(negedge clk);
    MemValid = 1'b0;
    total++; if (TLBWrite !== 1'b1) begin bad++; $display("FAIL w4k_write got=%0h exp=1", TLBWrite); end
    total++; if (PTE !== leaf) begin bad++; $display("FAIL w4k_pte got=%0h exp=%0h", PTE, leaf); end
    total++; if (PageType !== 2'd0) begin bad++; $display("FAIL w4k_type got=%0d exp=0", PageType); end
    total++; if (MemReq !== 1'b0) begin bad++; $display("FAIL w4k_req_off got=%0h exp=0", MemReq); end
    @(negedge clk);
    total++; if ({TLBWrite, Busy} !== 2'b00) begin bad++; $display("FAIL w4k_end got=%b exp=00", {TLBWrite, Busy}); end
  endtask

  task automatic test_walk_2m_wait();
    start_walk(44'h80000, {9'd4, 9'd5, 9'd6});
    MemValid = 1'b0;
    @(negedge clk);
    total++; if (MemReq !== 1'b1) begin bad++; $display("FAIL w2m_req_hold got=%0h exp=1", MemReq); end
    total++; if (MemAdr !== 56'h8000_0020) begin bad++; $display("FAIL w2m_adr_l2 got=%0h exp=80000020", MemAdr); end
    MemValid = 1'b1; MemRData = mk_pte(44'h80001, 4'b0001);
    @(negedge clk);
    total++; if (MemAdr !== 56'h8000_1028) begin bad++; $display("FAIL w2m_adr_l1 got=%0h exp=80001028", MemAdr); end
    MemRData = mk_pte(44'h80200, 4'b0011);
    @(negedge clk);
    MemValid = 1'b0;
    total++; if (TLBWrite !== 1'b1) begin bad++; $display("FAIL w2m_write got=%0h exp=1", TLBWrite); end
    total++; if (PageType !== 2'd1) begin bad++; $display("FAIL w2m_type got=%0d exp=1", PageType); end
    @(negedge clk);
    total++; if (TLBWrite !== 1'b0) begin bad++; $display("FAIL w2m_pulse got=%0h exp=0", TLBWrite); end
  endtask

  task automatic test_gigapage();
    logic [63:0] leaf;
    leaf = mk_pte(44'h40000, 4'b0011);
    start_walk(44'h80000, {9'd7, 9'd0, 9'd0});
    MemValid = 1'b1; MemRData = leaf;
    @(negedge clk);
    MemValid = 1'b0;
    total++; if (TLBWrite !== 1'b1) begin bad++; $display("FAIL giga_write got=%0h exp=1", TLBWrite); end
    total++; if (PageType !== 2'd2) begin bad++; $display("FAIL giga_type got=%0d exp=2", PageType); end
    total++; if (PTE !== leaf) begin bad++; $display("FAIL giga_pte got=%0h exp=%0h", PTE, leaf); end
    @(negedge clk);
  endtask

  task automatic test_faults();
    logic [63:0] ptes [4][3];
    int n [4];
    ptes[0][0] = mk_pte(44'h80001, 4'b0001); ptes[0][1] = mk_pte(44'h80002, 4'b1110); ptes[0][2] = '0; n[0] = 2;
    ptes[1][0] = mk_pte(44'h80001, 4'b0101); ptes[1][1] = '0; ptes[1][2] = '0; n[1] = 1;
    ptes[2][0] = mk_pte(44'h80001, 4'b0001); ptes[2][1] = mk_pte(44'h80002, 4'b0001);
    ptes[2][2] = mk_pte(44'h80003, 4'b0001); n[2] = 3;
    ptes[3][0] = mk_pte(44'h40001, 4'b0011); ptes[3][1] = '0; ptes[3][2] = '0; n[3] = 1;
    for (int f = 0; f < 4; f++) begin
      int k, wr, fc, fcyc;
      k = 0; wr = 0; fc = 0; fcyc = 0;
      start_walk(44'h80000, {9'd1, 9'd2, 9'd3});
      for (int c = 1; c <= 7; c++) begin
        if (TLBWrite) wr++;
        if (WalkFault) begin fc++; fcyc = c; end
        if (k < n[f]) begin MemValid = 1'b1; MemRData = ptes[f][k]; k++; end
        else MemValid = 1'b0;
        @(negedge clk);
      end
      total++; if (fc !== 1) begin bad++; $display("FAIL fault%0d_count got=%0d exp=1", f, fc); end
      total++; if (fcyc !== n[f] + 1) begin bad++; $display("FAIL fault%0d_cycle got=%0d exp=%0d", f, fcyc, n[f] + 1); end
      total++; if (wr !== 0) begin bad++; $display("FAIL fault%0d_write got=%0d exp=0", f, wr); end
    end
  endtask

  task automatic test_flush_wait();
    int wr;
    wr = 0;
    start_walk(44'h80000, {9'd1, 9'd2, 9'd3});
    MemValid = 1'b0; TLBFlush = 1'b1;
    @(negedge clk);
    TLBFlush = 1'b0;
    for (int c = 2; c <= 6; c++) begin
      total++; if ({MemReq, Busy} !== 2'b01) begin bad++; $display("FAIL flushw_drain%0d got=%b exp=01", c, {MemReq, Busy}); end
      if (TLBWrite) wr++;
      if (c == 6) begin MemValid = 1'b1; MemRData = mk_pte(44'h40000, 4'b0011); end
      @(negedge clk);
    end
    MemValid = 1'b0;
    total++; if ({MemReq, Busy, TLBWrite} !== 3'b000) begin bad++; $display("FAIL flushw_idle got=%b exp=000", {MemReq, Busy, TLBWrite}); end
    total++; if (wr !== 0) begin bad++; $display("FAIL flushw_write got=%0d exp=0", wr); end
    start_walk(44'h80000, {9'd2, 9'd0, 9'd0});
    total++; if (MemReq !== 1'b1) begin bad++; $display("FAIL flushw_newreq got=%0h exp=1", MemReq); end
    MemValid = 1'b1; MemRData = mk_pte(44'h40000, 4'b0011);
    @(negedge clk);
    MemValid = 1'b0;
    total++; if (TLBWrite !== 1'b1) begin bad++; $display("FAIL flushw_newwrite got=%0h exp=1", TLBWrite); end
    @(negedge clk);
  endtask

  task automatic test_flush_done();
    int wr, rq;
    start_walk(44'h80000, {9'd3, 9'd0, 9'd0});
    MemValid = 1'b1; MemRData = mk_pte(44'h40000, 4'b0011);
    @(negedge clk);
    MemValid = 1'b0; TLBFlush = 1'b1;
    #1;
    total++; if (TLBWrite !== 1'b0) begin bad++; $display("FAIL flushd_write got=%0h exp=0", TLBWrite); end
    @(negedge clk);
    TLBFlush = 1'b0;
    total++; if ({Busy, TLBWrite} !== 2'b00) begin bad++; $display("FAIL flushd_idle got=%b exp=00", {Busy, TLBWrite}); end
    // TLBMiss held high during a walk, with VPN changing, must not restart it.
    wr = 0; rq = 0;
    start_walk(44'h80000, {9'd1, 9'd2, 9'd3});
    TLBMiss = 1'b1; VPN = {9'd9, 9'd9, 9'd9};
    MemValid = 1'b1; MemRData = mk_pte(44'h80001, 4'b0001);
    rq++;
    @(negedge clk);
    total++; if (MemAdr !== 56'h8000_1010) begin bad++; $display("FAIL miss_ign_adr got=%0h exp=80001010", MemAdr); end
    if (MemReq) rq++;
    MemRData = mk_pte(44'h80200, 4'b0011);
    @(negedge clk);
    MemValid = 1'b0;
    if (TLBWrite) begin wr++; TLBMiss = 1'b0; end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      TLBMiss = 1'b0;
      if (TLBWrite) wr++;
      if (MemReq) rq++;
    end
    total++; if (wr !== 1) begin bad++; $display("FAIL miss_ign_writes got=%0d exp=1", wr); end
    total++; if (rq !== 2) begin bad++; $display("FAIL miss_ign_reqs got=%0d exp=2", rq); end
  endtask

  task automatic test_reset_mid_walk();
    start_walk(44'h80000, {9'd1, 9'd2, 9'd3});
    MemValid = 1'b1; MemRData = mk_pte(44'h80001, 4'b0001);
    @(negedge clk);
    MemValid = 1'b0;
    #2 reset = 1'b0;
    #1;
    total++; if ({MemReq, Busy, TLBWrite, WalkFault} !== 4'b0000) begin bad++; $display("FAIL rstmid_flags got=%b exp=0000", {MemReq, Busy, TLBWrite, WalkFault}); end
    total++; if ({MemAdr, PTE, PageType} !== '0) begin bad++; $display("FAIL rstmid_data got=%0h exp=0", {MemAdr, PTE, PageType}); end
    @(negedge clk);
    reset = 1'b1;
    MemValid = 1'b1; MemRData = mk_pte(44'h80200, 4'b0011);
    @(negedge clk);
    MemValid = 1'b0;
    total++; if ({MemReq, Busy, TLBWrite, WalkFault} !== 4'b0000) begin bad++; $display("FAIL rstmid_late got=%b exp=0000", {MemReq, Busy, TLBWrite, WalkFault}); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_walk_4k();
    test_walk_2m_wait();
    test_gigapage();
    test_faults();
    test_flush_wait();
    test_flush_done();
    test_reset_mid_walk();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
